// File: rtl/hydra_pkg.sv
// hydra_pkg: shared data width, header field positions and read-side FSM states
package hydra_pkg;
  localparam int DATA_W = 16;
  localparam int LEN_HI = 15;
  localparam int LEN_LO = 7;
  localparam int PRIO_HI = 6;
  localparam int PRIO_LO = 4;
  localparam int DEST_HI = 3;
  localparam int DEST_LO = 0;
  typedef enum logic [1:0] {IDLE, SOP, DATA, EOP} rd_state_t;
endpackage

// File: rtl/port_rd_fifo.sv
// port_rd_fifo: synchronous FIFO of data words tagged with a last-of-packet flag
module port_rd_fifo #(
  parameter int DEPTH = 64,
  parameter int W = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic accept;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  // a full buffer still takes a word when the same cycle frees a slot
  assign accept = push && (!full || pop);
  assign count_next = count + CW'(accept) - CW'(pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/port_rd_frontend.sv
// port_rd_frontend: buffers backend packet words and replays them as sop/vld/eop under ready
module port_rd_frontend
  import hydra_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int PAUSE_MARGIN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              xfer_data_vld,
  input  logic [DATA_W-1:0] xfer_data,
  input  logic              end_of_packet,
  output logic              xfer_pause,
  input  logic              ready,
  output logic              rd_sop,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_eop,
  output logic              pkt_done,
  output logic              len_err,
  output logic              ovf_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int LW = LEN_HI - LEN_LO + 1;
  localparam logic [CW-1:0] PAUSE_AT = CW'(DEPTH - PAUSE_MARGIN);
  rd_state_t state;
  logic pop, full, empty, first;
  logic [DATA_W:0] dout;
  logic [CW-1:0] count_next;
  logic [LW-1:0] hdr_len, dcnt, dcnt_inc, cnt_now, len_now;
  assign pop = (state == DATA) && ready && !empty;
  assign dcnt_inc = &dcnt ? dcnt : dcnt + 1'b1;
  // the header pop restarts the count and supplies the expected length itself
  assign cnt_now = first ? '0 : dcnt_inc;
  assign len_now = first ? dout[LEN_HI:LEN_LO] : hdr_len;
  port_rd_fifo #(.DEPTH(DEPTH), .W(DATA_W + 1)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(xfer_data_vld),
    .pop(pop),
    .din({end_of_packet, xfer_data}),
    .dout(dout),
    .count_next(count_next),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd_sop <= 1'b0;
      rd_vld <= 1'b0;
      rd_data <= '0;
      rd_eop <= 1'b0;
      pkt_done <= 1'b0;
      len_err <= 1'b0;
      ovf_err <= 1'b0;
      xfer_pause <= 1'b0;
      first <= 1'b0;
      hdr_len <= '0;
      dcnt <= '0;
    end else begin
      xfer_pause <= count_next >= PAUSE_AT;
      if (xfer_data_vld && full && !pop) ovf_err <= 1'b1;
      rd_sop <= 1'b0;
      rd_eop <= 1'b0;
      pkt_done <= 1'b0;
      rd_vld <= pop;
      case (state)
        IDLE: if (ready && !empty) begin
          state <= SOP;
          rd_sop <= 1'b1;
          first <= 1'b1;
        end
        SOP: state <= DATA;
        DATA: if (pop) begin
          rd_data <= dout[DATA_W-1:0];
          hdr_len <= len_now;
          dcnt <= cnt_now;
          first <= 1'b0;
          if (dout[DATA_W]) begin
            state <= EOP;
            rd_eop <= 1'b1;
            pkt_done <= 1'b1;
            if (cnt_now != len_now) len_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
